// File: rtl/spi_pkg.sv
// spi_pkg -- shared types and helpers for the SPI responder.
//   spi_state_e      : frame state (IDLE / ACTIVE)
//   SYNC_STAGES      : synchroniser depth ahead of the edge-detect register
//   lead_is_rise()   : true when the leading SCLK edge is a rising edge
//   sample_on_lead() : true when MOSI is sampled on the leading edge
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

    localparam int SYNC_STAGES = 2;

    // Leading edge is the idle->active transition of SCLK.
    function automatic logic lead_is_rise(input logic cpol);
        return !cpol;
    endfunction

    function automatic logic sample_on_lead(input logic cpha);
        return !cpha;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// spi_slave_sync -- synchroniser for one asynchronous pin plus an edge register.
//   i_clk_sys, i_rst_n : system clock, async active-low reset
//   i_d                : asynchronous input pin
//   o_level            : synchronised level
//   o_rise / o_fall    : single-cycle pulses on synchronised edges
// RST_VAL is the idle level of the pin, so no edge is reported after reset.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk_sys,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // sr[0..SYNC_STAGES-1] synchronise, sr[SYNC_STAGES] holds the previous level.
    logic [SYNC_STAGES:0] sr;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) sr <= {(SYNC_STAGES + 1){RST_VAL}};
        else          sr <= {sr[SYNC_STAGES-1:0], i_d};
    end

    assign o_level = sr[SYNC_STAGES-1];
    assign o_rise  = sr[SYNC_STAGES-1] & ~sr[SYNC_STAGES];
    assign o_fall  = ~sr[SYNC_STAGES-1] & sr[SYNC_STAGES];

endmodule

// File: rtl/spi_slave_core.sv
// spi_slave_core -- SPI responder, all four CPOL/CPHA modes, oversampled in i_clk_sys.
//   i_clk_sys, i_rst_n      : system clock (>= 4x SCLK), async active-low reset
//   i_SCLK, i_CS_n, i_MOSI  : asynchronous SPI pins from the master
//   o_MISO                  : serial data out (0 while idle in the default build)
//   o_MISO_oe               : only with SPI_SLAVE_MISO_OE_EN; equals o_busy, and
//                             o_MISO then holds its last value while idle
//   i_tx_data/i_tx_valid/o_tx_ready : single-entry TX holding register
//   o_rx_data/o_rx_valid    : last received word, one-cycle update pulse
//   o_busy                  : frame active
module spi_slave_core
    import spi_pkg::*;
#(
    parameter logic CPOL       = 1'b0,
    parameter logic CPHA       = 1'b0,
    parameter int   DATA_WIDTH = 8,
    parameter logic MSB_FIRST  = 1'b1
) (
    input  logic                  i_clk_sys,
    input  logic                  i_rst_n,
    input  logic                  i_SCLK,
    input  logic                  i_CS_n,
    input  logic                  i_MOSI,
    output logic                  o_MISO,
`ifdef SPI_SLAVE_MISO_OE_EN
    output logic                  o_MISO_oe,
`endif
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_busy
);

    localparam int   CW          = $clog2(DATA_WIDTH);
    localparam logic LEAD_RISE   = lead_is_rise(CPOL);
    localparam logic SAMPLE_LEAD = sample_on_lead(CPHA);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic cs_lvl_unused, cs_rise, cs_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_slave_sync #(.RST_VAL(CPOL)) u_sync_sclk (
        .i_clk_sys(i_clk_sys), .i_rst_n(i_rst_n), .i_d(i_SCLK),
        .o_level(sclk_lvl_unused), .o_rise(sclk_rise), .o_fall(sclk_fall)
    );
    spi_slave_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .i_clk_sys(i_clk_sys), .i_rst_n(i_rst_n), .i_d(i_CS_n),
        .o_level(cs_lvl_unused), .o_rise(cs_rise), .o_fall(cs_fall)
    );
    spi_slave_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk_sys(i_clk_sys), .i_rst_n(i_rst_n), .i_d(i_MOSI),
        .o_level(mosi_s), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused)
    );

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = LEAD_RISE ? sclk_rise : sclk_fall;
    assign trail_edge  = LEAD_RISE ? sclk_fall : sclk_rise;
    assign sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
    assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;

    // ---------------- frame FSM ----------------
    spi_state_e state, state_nxt;
    logic       frame_start, active;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // A CS_n rise masks any SCLK edge in the same cycle, so an abort never
    // completes a word.
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        active      = 1'b0;
        case (state)
            IDLE: if (cs_fall) begin
                state_nxt   = ACTIVE;
                frame_start = 1'b1;
            end
            ACTIVE: if (cs_rise) state_nxt = IDLE;
                    else         active    = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic [DATA_WIDTH-1:0] hold_data, tx_sr, rx_sr, rx_nxt, hold_word, tx_src, tx_adv;
    logic                  hold_full, tx_pend, miso_q, tx_bit;
    logic [CW-1:0]         bit_cnt;
    logic                  smp, shf, reload, load, present;

    assign smp       = active && sample_edge;
    assign shf       = active && shift_edge;
    assign hold_word = hold_full ? hold_data : '0;   // underrun sends zeros
    // tx_pend: word loaded at frame start (CPHA=1) but its first bit not yet shown.
    assign reload    = shf && !tx_pend && (bit_cnt == '0);
    assign load      = frame_start || reload;
    assign present   = shf || (frame_start && (CPHA == 1'b0));
    assign tx_src    = load ? hold_word : tx_sr;
    assign tx_bit    = MSB_FIRST ? tx_src[DATA_WIDTH-1] : tx_src[0];
    assign tx_adv    = MSB_FIRST ? (tx_src << 1) : (tx_src >> 1);
    assign rx_nxt    = MSB_FIRST ? {rx_sr[DATA_WIDTH-2:0], mosi_s}
                                 : {mosi_s, rx_sr[DATA_WIDTH-1:1]};

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_data  <= '0;
            hold_full  <= 1'b0;
            tx_sr      <= '0;
            tx_pend    <= 1'b0;
            miso_q     <= 1'b0;
            rx_sr      <= '0;
            bit_cnt    <= '0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            o_rx_valid <= 1'b0;

            if (present) begin
                miso_q  <= tx_bit;
                tx_sr   <= tx_adv;
                tx_pend <= 1'b0;
            end else if (frame_start) begin
                tx_sr   <= hold_word;
                tx_pend <= 1'b1;
            end

            if (frame_start) bit_cnt <= '0;

            if (smp) begin
                rx_sr <= rx_nxt;
                if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                    bit_cnt    <= '0;
                    o_rx_data  <= rx_nxt;
                    o_rx_valid <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end

            // Load consumes the old contents first; a same-cycle handshake
            // then refills the register.
            if (load) hold_full <= 1'b0;
            if (i_tx_valid && !hold_full) begin
                hold_full <= 1'b1;
                hold_data <= i_tx_data;
            end
        end
    end

    assign o_tx_ready = !hold_full;
    assign o_busy     = (state == ACTIVE);

`ifdef SPI_SLAVE_MISO_OE_EN
    assign o_MISO    = miso_q;
    assign o_MISO_oe = o_busy;
`else
    assign o_MISO    = o_busy & miso_q;
`endif

endmodule

// File: tb/tb_spi_slave_core.sv
// Testbench for spi_slave_core. Eight instances cover CPHA x CPOL x MSB_FIRST
// (index k = cpha*4 + cpol*2 + msb). Instances sharing a CPHA share CS_n/MOSI;
// SCLK is the group's logical clock XOR CPOL. The master samples MISO one
// half-period after its sample edge, just before it drives the next edge.
module tb_spi_slave_core;
    localparam int HALF = 2;  // SCLK half-period in i_clk_sys cycles (ratio 4)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       cs_g[2], sclk_g[2], mosi_g[2];
    logic       miso[8], rx_valid[8], busy[8], tx_ready[8], tx_valid[8];
    logic [7:0] rx_data[8], tx_data[8];
`ifdef SPI_SLAVE_MISO_OE_EN
    logic       oe[8];
`endif

    int          checks = 0, failures = 0;
    int          vcnt[8] = '{default: 0};
    logic [7:0]  rx_log[8][16];
    logic [63:0] got[8];
    logic        last_miso[8];

    for (genvar g = 0; g < 8; g++) begin : gi
        localparam logic CPHA_G = 1'((g / 4) % 2);
        localparam logic CPOL_G = 1'((g / 2) % 2);
        localparam logic MSB_G  = 1'(g % 2);
        spi_slave_core #(.CPOL(CPOL_G), .CPHA(CPHA_G), .DATA_WIDTH(8), .MSB_FIRST(MSB_G)) u_dut (
            .i_clk_sys (clk),
            .i_rst_n   (rst_n),
            .i_SCLK    (sclk_g[g/4] ^ CPOL_G),
            .i_CS_n    (cs_g[g/4]),
            .i_MOSI    (mosi_g[g/4]),
            .o_MISO    (miso[g]),
`ifdef SPI_SLAVE_MISO_OE_EN
            .o_MISO_oe (oe[g]),
`endif
            .i_tx_data (tx_data[g]),
            .i_tx_valid(tx_valid[g]),
            .o_tx_ready(tx_ready[g]),
            .o_rx_data (rx_data[g]),
            .o_rx_valid(rx_valid[g]),
            .o_busy    (busy[g])
        );
    end

    // Count rx_valid pulses (sampled away from the active edge) and log the words.
    always @(negedge clk) begin
        for (int k = 0; k < 8; k++)
            if (rx_valid[k] === 1'b1) begin
                rx_log[k][vcnt[k] % 16] <= rx_data[k];
                vcnt[k]                 <= vcnt[k] + 1;
            end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Bit j of a serial stream <-> word, given the bit order (self-inverse).
    function automatic logic [7:0] ord(input logic [7:0] w, input bit msb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return msb ? r : w;
    endfunction

    task automatic load_tx(input int k, input logic [7:0] d);
        tx_data[k]  = d;
        tx_valid[k] = 1'b1;
        tick(1);
        tx_valid[k] = 1'b0;
    endtask

    // Drive one CS_n frame on group grp (== CPHA) with nbits stream bits.
    task automatic frame(input int grp, input int nbits, input logic [63:0] bits, input bit close);
        cs_g[grp] = 1'b0;
        if (grp == 0) mosi_g[grp] = bits[0];
        tick(4);
        for (int c = 0; c < 4; c++) begin
            chk("busy_active", busy[grp*4+c], 1);
`ifdef SPI_SLAVE_MISO_OE_EN
            chk("oe_active", oe[grp*4+c], 1);
`endif
        end
        for (int j = 0; j < nbits; j++) begin
            sclk_g[grp] = 1'b1;
            if (grp == 1) mosi_g[grp] = bits[j];
            tick(HALF);
            if (grp == 0) for (int c = 0; c < 4; c++) got[grp*4+c][j] = miso[grp*4+c];
            sclk_g[grp] = 1'b0;
            if (grp == 0) mosi_g[grp] = bits[j+1];
            tick(HALF);
            if (grp == 1) for (int c = 0; c < 4; c++) got[grp*4+c][j] = miso[grp*4+c];
        end
        if (close) begin
            tick(2);
            for (int c = 0; c < 4; c++) last_miso[grp*4+c] = miso[grp*4+c];
            cs_g[grp] = 1'b1;
            tick(6);
            for (int c = 0; c < 4; c++) begin
                chk("busy_idle", busy[grp*4+c], 0);
`ifdef SPI_SLAVE_MISO_OE_EN
                chk("oe_idle", oe[grp*4+c], 0);
                chk("miso_hold", miso[grp*4+c], last_miso[grp*4+c]);
`else
                chk("miso_idle", miso[grp*4+c], 0);
`endif
            end
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_miso"},     miso[k],     0);
            chk({tag, "_rx_data"},  rx_data[k],  0);
            chk({tag, "_rx_valid"}, rx_valid[k], 0);
            chk({tag, "_busy"},     busy[k],     0);
            chk({tag, "_tx_ready"}, tx_ready[k], 1);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] mosi_w;
        logic [7:0] tx_w;
        logic [7:0] exp_rx;
        logic [7:0] exp_master;
    } vec_t;

    initial begin
        vec_t       tbl[9];
        int         v0, k;
        bit         msb;
        logic [7:0] txw[4];
        int         v0s[4];
        logic [15:0] st;

        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin tx_valid[i] = 1'b0; tx_data[i] = '0; end
        for (int i = 0; i < 2; i++) begin cs_g[i] = 1'b1; sclk_g[i] = 1'b0; mosi_g[i] = 1'b0; end
        tick(3);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick(3);

        // ---- table: mode-0 round trip, then all four modes x both bit orders ----
        tbl[0] = '{1, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        for (int i = 0; i < 8; i++) tbl[i+1] = '{i, 8'h81, 8'h7E, 8'h81, 8'h7E};
        for (int i = 0; i < 9; i++) begin
            k   = tbl[i].k;
            msb = (k % 2) == 1;
            load_tx(k, tbl[i].tx_w);
            chk("tx_ready_full", tx_ready[k], 0);
            v0 = vcnt[k];
            frame(k / 4, 8, {56'b0, ord(tbl[i].mosi_w, msb)}, 1'b1);
            chk("rx_pulses", vcnt[k] - v0, 1);
            chk("rx_data", rx_data[k], tbl[i].exp_rx);
            chk("master_rx", ord(got[k][7:0], msb), tbl[i].exp_master);
            chk("tx_ready_empty", tx_ready[k], 1);
        end

        // ---- two words in one frame, only the first preloaded ----
        load_tx(1, 8'h11);
        chk("uf_ready_full", tx_ready[1], 0);
        v0 = vcnt[1];
        frame(0, 16, {48'b0, ord(8'hC3, 1'b1), ord(8'h5A, 1'b1)}, 1'b1);
        chk("uf_pulses", vcnt[1] - v0, 2);
        chk("uf_rx0", rx_log[1][v0 % 16], 8'h5A);
        chk("uf_rx1", rx_log[1][(v0 + 1) % 16], 8'hC3);
        chk("uf_master0", ord(got[1][7:0], 1'b1), 8'h11);
        chk("uf_master1", ord(got[1][15:8], 1'b1), 8'h00);
        chk("uf_ready", tx_ready[1], 1);

        // ---- CS_n abort after 5 bits, then a clean frame ----
        load_tx(1, 8'h55);
        v0 = vcnt[1];
        frame(0, 5, {56'b0, ord(8'hFF, 1'b1)}, 1'b1);
        chk("abort_no_pulse", vcnt[1] - v0, 0);
        chk("abort_rx_data_kept", rx_data[1], 8'hC3);
        load_tx(1, 8'h96);
        v0 = vcnt[1];
        frame(0, 8, {56'b0, ord(8'hE7, 1'b1)}, 1'b1);
        chk("post_abort_pulses", vcnt[1] - v0, 1);
        chk("post_abort_rx", rx_data[1], 8'hE7);
        chk("post_abort_master", ord(got[1][7:0], 1'b1), 8'h96);

        // ---- reset after 3 bits ----
        load_tx(1, 8'h33);
        frame(0, 3, {56'b0, ord(8'hA0, 1'b1)}, 1'b0);
        rst_n = 1'b0;
        tick(1);
        chk_reset_vals("midrst");
        cs_g[0]   = 1'b1;
        sclk_g[0] = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        load_tx(1, 8'hC8);
        v0 = vcnt[1];
        frame(0, 8, {56'b0, ord(8'h4D, 1'b1)}, 1'b1);
        chk("post_rst_pulses", vcnt[1] - v0, 1);
        chk("post_rst_rx", rx_data[1], 8'h4D);
        chk("post_rst_master", ord(got[1][7:0], 1'b1), 8'hC8);

        // ---- random two-word frames against the reference model ----
        for (int it = 0; it < 16; it++) begin
            int grp;
            grp = int'($urandom_range(0, 1));
            for (int c = 0; c < 4; c++) begin
                k           = grp * 4 + c;
                txw[c]      = 8'($urandom);
                tx_data[k]  = txw[c];
                tx_valid[k] = 1'b1;
                v0s[c]      = vcnt[k];
            end
            tick(1);
            for (int c = 0; c < 4; c++) tx_valid[grp*4+c] = 1'b0;
            st = 16'($urandom);
            frame(grp, 16, {48'b0, st}, 1'b1);
            for (int c = 0; c < 4; c++) begin
                k   = grp * 4 + c;
                msb = (c % 2) == 1;
                chk("rnd_pulses", vcnt[k] - v0s[c], 2);
                chk("rnd_rx0", rx_log[k][v0s[c] % 16], ord(st[7:0], msb));
                chk("rnd_rx1", rx_log[k][(v0s[c] + 1) % 16], ord(st[15:8], msb));
                chk("rnd_master0", ord(got[k][7:0], msb), txw[c]);
                chk("rnd_master1", ord(got[k][15:8], msb), 8'h00);
                chk("rnd_ready", tx_ready[k], 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
# spi_slave_core

SPI responder for the far end of the link driven by the team's SPI master and its SCLK generator. It oversamples SCLK, CS_n and MOSI in the i_clk_sys domain, deserialises MOSI into parallel words, and serialises a buffered transmit word onto MISO. The block supports all four CPOL/CPHA modes. It sits between the board-level SPI pins and a simple valid/ready register interface.

## Interface
- CPOL, 1'b0: SCLK idle level; must match the master.
- CPHA, 1'b0: 0 = sample on leading edge, 1 = sample on trailing edge.
- DATA_WIDTH, 8: bits per word, legal range 2..32.
- MSB_FIRST, 1'b1: 1 = MSB shifted first; 0 = LSB first.
- i_clk_sys  in  1  system clock; frequency ≥ 4× SCLK frequency.
- i_rst_n  in  1  reset, asynchronous, active-low; clock i_clk_sys.
- i_SCLK  in  1  SPI clock from the master; asynchronous.
- i_CS_n  in  1  chip select, active-low; asynchronous.
- i_MOSI  in  1  serial data in; asynchronous.
- o_MISO  out  1  serial data out.
- i_tx_data  in  DATA_WIDTH  next word to transmit.
- i_tx_valid  in  1  i_tx_data is valid.
- o_tx_ready  out  1  TX holding register is empty; the word is accepted when valid and ready are both high.
- o_rx_data  out  DATA_WIDTH  last complete received word; held until the next word completes.
- o_rx_valid  out  1  one-cycle pulse when o_rx_data updates.
- o_busy  out  1  frame active (synchronised CS_n low).

## Operation
- **Input synchronisation.** i_SCLK, i_CS_n and i_MOSI each pass through a 2-FF synchroniser, followed by a third register for edge detection.
  - Leading edge = the idle→active SCLK transition (rising edge when CPOL=0).
  - Trailing edge = the reverse transition.
- **States.** IDLE and ACTIVE.
  - IDLE→ACTIVE on the synchronised CS_n falling edge.
  - ACTIVE→IDLE on the synchronised CS_n rising edge, from any bit position.
- **Frame start.**
  - The shift register loads from the holding register if it is full, which empties it; otherwise it loads all zeros (underrun).
  - The bit counter is cleared to 0.
  - With CPHA=0, the first TX bit appears on o_MISO at frame start.
- **Sample edge** (leading edge if CPHA=0, trailing edge if CPHA=1):
  - Capture the synchronised MOSI into the RX shift register.
  - Increment the bit counter.
  - When the counter reaches DATA_WIDTH: o_rx_data ← the assembled word, o_rx_valid pulses, counter wraps to 0.
- **Shift edge** (the opposite edge):
  - Advance the TX shift register and present the next bit.
  - With CPHA=1, the first bit is presented on the first leading edge.
  - At a word boundary with CS_n still low, reload the shift register from the holding register, or all zeros if it is empty.
- **Holding register.** Single entry. o_tx_ready = !full. The register fills on a valid&&ready handshake and empties on a shift-register load.
- **Back-pressure.** There is none on RX. A new word overwrites o_rx_data regardless of whether the consumer has read it.
- **CS_n abort.** A CS_n rise mid-word discards the partial RX word (no o_rx_valid pulse) and the partial TX word. The holding register keeps its contents.
- **o_MISO when idle.** o_MISO = 0 whenever the block is IDLE.

## Timing
- **Reset values:**
  - o_MISO = 0, o_rx_data = 0, o_rx_valid = 0, o_busy = 0, o_tx_ready = 1.
  - State IDLE, counter 0, holding register empty.
- **Pin-to-edge latency.** An edge on a pin is detected 3 i_clk_sys cycles later.
- **o_rx_valid.** Rises in the cycle after the final sample-edge detect and lasts exactly 1 cycle.
- **o_MISO.** Updates 1 cycle after the shift-edge detect, giving ≤ 4 cycles from the SCLK pin edge. This is why a ratio of ≥ 4 is required.
- **o_busy.** Follows the synchronised CS_n with 3 cycles of latency.
- **Handshake.** A handshake in the same cycle as a shift-register load does not collide: the load takes the old holding contents first, and the new word is then written.
- **Simultaneous CS_n rise and sample edge.** The CS_n rise wins; no pulse is generated.
- **Reset mid-frame.** Reset returns all state to the reset values immediately.

## Configuration
- **SPI_SLAVE_MISO_OE_EN defined:**
  - Adds port o_MISO_oe (out, 1 bit), equal to o_busy; reset value 0.
  - o_MISO holds its last value when IDLE; the pad tristates it externally.
- **SPI_SLAVE_MISO_OE_EN undefined:** no o_MISO_oe port; o_MISO is forced to 0 when IDLE.

## Structure
- **Package spi_pkg:**
  - State enum (IDLE, ACTIVE).
  - Constant SYNC_STAGES = 2.
  - Edge-select helper localparams derived from CPOL and CPHA.
- **Sub-module spi_slave_sync:**
  - 3-stage synchroniser with rise and fall pulse outputs.
  - Instantiated once each for SCLK, CS_n and MOSI; only the level output is used for MOSI.

## Test plan
- **Mode 0 round trip.** Mode 0, DATA_WIDTH=8, i_clk_sys/SCLK = 4. Preload TX 0xA5; master sends 0x3C. Expect o_rx_data=0x3C with one o_rx_valid pulse, and the master receives 0xA5.
- **All four modes.** Run each CPOL/CPHA combination with master TX 0x81 and slave TX 0x7E. Both directions must match in every mode, with MSB_FIRST=1 and MSB_FIRST=0.
- **Back-to-back words with underrun.** Two words in one CS_n frame; holding register filled with 0x11 only. Expect slave TX 0x11 then 0x00; o_tx_ready returns to 1 after the first load.
- **CS_n abort.** CS_n rises after 5 bits. Expect no o_rx_valid, o_busy=0, and the next full frame receives correctly.
- **Reset mid-frame.** Assert i_rst_n low after 3 bits. Expect all outputs at their reset values; the following frame is error-free.
- **Macro build.** Build with SPI_SLAVE_MISO_OE_EN defined. Expect o_MISO_oe to track o_busy, and o_MISO to hold its last value when idle.
